// File: rtl/player_pkg.sv
// player_pkg: player sprite geometry, colours and the floor offset shared with the controller.
package player_pkg;
  localparam int PLAYER_W = 32;
  localparam int PLAYER_H = 48;
  localparam int LEG_H    = 12;
  localparam int Y_OFFSET = 500;
  localparam logic [11:0] BODY_RGB    = 12'h0_8_F;
  localparam logic [11:0] LEG_RGB     = 12'h3_3_3;
  localparam logic [11:0] EYE_RGB     = 12'hF_F_F;
  localparam logic [11:0] OUTLINE_RGB = 12'h0_0_0;
  function automatic logic in_rng(input logic [12:0] v, input int lo, input int hi);
    return int'(v) >= lo && int'(v) <= hi;
  endfunction
endpackage

// File: rtl/state_pkg.sv
// state_pkg: player movement state shared by the movement controller and sprite drawer.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RIGHT1 = 2'd1,
    LEFT1  = 2'd2
  } State;
endpackage

// File: rtl/player_anim_ctl.sv
// player_anim_ctl: latches player position/state on the vblnk rising edge and derives
// facing direction and walking animation phase once per frame.
module player_anim_ctl
  import state_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk_i,
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  input  State        state_i,
  output logic [11:0] x_l_o,
  output logic [11:0] y_l_o,
  output logic        face_left_o,
  output logic        anim_phase_o
);
  localparam int CW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  logic          vblnk_q;
  logic [CW-1:0] cnt_q;
  logic          latch, wrap;
  assign latch = vblnk_i && !vblnk_q;
  assign wrap  = cnt_q == CW'(ANIM_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q      <= 1'b0;
      x_l_o        <= '0;
      y_l_o        <= '0;
      face_left_o  <= 1'b0;
      anim_phase_o <= 1'b0;
      cnt_q        <= '0;
    end else begin
      vblnk_q <= vblnk_i;
      if (latch) begin
        x_l_o        <= xpos_i;
        y_l_o        <= ypos_i;
        face_left_o  <= state_i == LEFT1 ? 1'b1 : state_i == RIGHT1 ? 1'b0 : face_left_o;
        cnt_q        <= state_i == IDLE || wrap ? '0 : cnt_q + 1'b1;
        anim_phase_o <= state_i == IDLE ? 1'b0 : anim_phase_o ^ wrap;
      end
    end
  end
endmodule

// File: rtl/draw_player.sv
// draw_player: overlays the animated player sprite on the VGA stream with a fixed 2-cycle delay.
// Optional PLAYER_OUTLINE_EN draws a black outline around the sprite.
module draw_player
  import state_pkg::*;
#(
  parameter int          PLAYER_W = player_pkg::PLAYER_W,
  parameter int          PLAYER_H = player_pkg::PLAYER_H,
  parameter int          Y_OFFSET = player_pkg::Y_OFFSET,
  parameter int          LEG_H    = player_pkg::LEG_H,
  parameter int          ANIM_DIV = 8,
  parameter logic [11:0] BODY_RGB = player_pkg::BODY_RGB,
  parameter logic [11:0] LEG_RGB  = player_pkg::LEG_RGB,
  parameter logic [11:0] EYE_RGB  = player_pkg::EYE_RGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] ypos_player1,
  input  State        state,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  import player_pkg::in_rng;
  localparam int S = PLAYER_W / 32;
  localparam logic signed [12:0] PW_S = 13'(PLAYER_W);
  localparam logic signed [12:0] PH_S = 13'(PLAYER_H);
  logic [11:0] x_l, y_l;
  logic        face_left, anim_phase;
  player_anim_ctl #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .clk         (clk),
    .rst         (rst),
    .vblnk_i     (vblnk_in),
    .xpos_i      (xpos_player1),
    .ypos_i      (ypos_player1),
    .state_i     (state),
    .x_l_o       (x_l),
    .y_l_o       (y_l),
    .face_left_o (face_left),
    .anim_phase_o(anim_phase)
  );
  // 13-bit signed offsets keep positions past the right/bottom edge from aliasing to 0
  logic signed [12:0] rel_x, rel_y;
  logic               in_box;
  assign rel_x  = $signed({2'b0, hcount_in} - {1'b0, x_l});
  assign rel_y  = $signed({2'b0, vcount_in} - (13'(Y_OFFSET) + {1'b0, y_l}));
  assign in_box = !hblnk_in && !vblnk_in && rel_x >= 0 && rel_x < PW_S && rel_y >= 0 && rel_y < PH_S;
  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, hblnk_q, vsync_q, vblnk_q, in_box_q;
  logic [11:0] rgb_q;
  logic [12:0] rx_q, ry_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      {hcount_q, hsync_q, hblnk_q, vcount_q, vsync_q, vblnk_q} <= '0;
      {rgb_q, in_box_q, rx_q, ry_q} <= '0;
    end else begin
      {hcount_q, hsync_q, hblnk_q} <= {hcount_in, hsync_in, hblnk_in};
      {vcount_q, vsync_q, vblnk_q} <= {vcount_in, vsync_in, vblnk_in};
      {rgb_q, in_box_q} <= {rgb_in, in_box};
      {rx_q, ry_q} <= {rel_x, rel_y};
    end
  end
  logic        leg_band, leg, eye, edge_px;
  logic [11:0] rgb_d;
  assign leg_band = in_rng(ry_q, PLAYER_H - LEG_H, PLAYER_H - 1);
  assign leg = anim_phase ? in_rng(rx_q, 8*S, 16*S - 1) || in_rng(rx_q, 16*S, 24*S - 1)
                          : in_rng(rx_q, 4*S, 12*S - 1) || in_rng(rx_q, 20*S, 28*S - 1);
  assign eye = in_rng(ry_q, 8, 11) &&
               (face_left ? in_rng(rx_q, 6, 9) : in_rng(rx_q, PLAYER_W - 10, PLAYER_W - 7));
`ifdef PLAYER_OUTLINE_EN
  assign edge_px = in_rng(rx_q, 0, 0) || in_rng(rx_q, PLAYER_W - 1, PLAYER_W - 1) ||
                   in_rng(ry_q, 0, 0) || in_rng(ry_q, PLAYER_H - 1, PLAYER_H - 1);
`else
  assign edge_px = 1'b0;
`endif
  assign rgb_d = !in_box_q                   ? rgb_q :
                 edge_px && !(leg_band && !leg) ? player_pkg::OUTLINE_RGB :
                 leg_band                    ? (leg ? LEG_RGB : rgb_q) :
                 eye                         ? EYE_RGB : BODY_RGB;
  always_ff @(posedge clk) begin
    if (rst) begin
      {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out} <= '0;
    end else begin
      {hcount_out, hsync_out, hblnk_out} <= {hcount_q, hsync_q, hblnk_q};
      {vcount_out, vsync_out, vblnk_out} <= {vcount_q, vsync_q, vblnk_q};
      rgb_out <= rgb_d;
    end
  end
endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: directed and random stimulus checked every cycle against a frame/pixel model.
module tb_draw_player;
  import state_pkg::*;
  localparam logic [11:0] BODY = 12'h08F, LEG = 12'h333, EYE = 12'hFFF, BG = 12'h5A5;
`ifdef PLAYER_OUTLINE_EN
  localparam logic [11:0] EDGE_C = 12'h000;
`else
  localparam logic [11:0] EDGE_C = 12'h08F;
`endif
  logic        clk = 0, rst = 1;
  logic [11:0] xp = 0, yp = 0, rgb = 0;
  State        st = IDLE;
  logic [10:0] h = 0, v = 0;
  logic        hs = 0, hb = 0, vs = 0, vb = 0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [37:0] dutv;
  int errors = 0, checks = 0;
  int mx = 0, my = 0, mcnt = 0;
  bit mface = 0, mphase = 0, mprev = 0;
  logic [37:0] m_s1 = '0, m_out = '0;

  draw_player dut (
    .clk(clk), .rst(rst), .xpos_player1(xp), .ypos_player1(yp), .state(st),
    .hcount_in(h), .hsync_in(hs), .hblnk_in(hb), .vcount_in(v), .vsync_in(vs), .vblnk_in(vb),
    .rgb_in(rgb), .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );
  assign dutv = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};

  always #5 clk = ~clk;

  function automatic logic [11:0] model_rgb(int hh, int vv, bit hbk, bit vbk, logic [11:0] c);
    int rx = hh - mx;
    int ry = vv - (500 + my);
    bit leg, gap;
    if (hbk || vbk || rx < 0 || rx >= 32 || ry < 0 || ry >= 48) return c;
    leg = mphase ? (rx >= 8 && rx <= 23) : ((rx >= 4 && rx <= 11) || (rx >= 20 && rx <= 27));
    gap = ry >= 36 && !leg;
`ifdef PLAYER_OUTLINE_EN
    if (!gap && (rx == 0 || rx == 31 || ry == 0 || ry == 47)) return 12'h000;
`endif
    if (ry >= 36) return leg ? LEG : c;
    if (ry >= 8 && ry <= 11 && (mface ? (rx >= 6 && rx <= 9) : (rx >= 22 && rx <= 25))) return EYE;
    return BODY;
  endfunction

  task automatic cyc();
    logic [37:0] pix;
    @(posedge clk);
    pix = {h, hs, hb, v, vs, vb, model_rgb(int'(h), int'(v), hb, vb, rgb)};
    if (rst) begin
      m_out = '0; m_s1 = '0; mx = 0; my = 0; mcnt = 0; mface = 0; mphase = 0; mprev = 0;
    end else begin
      m_out = m_s1;
      m_s1 = pix;
      if (vb && !mprev) begin
        mx = int'(xp);
        my = int'(yp);
        if (st == LEFT1) mface = 1;
        else if (st == RIGHT1) mface = 0;
        if (st == IDLE) begin
          mcnt = 0;
          mphase = 0;
        end else begin
          mcnt++;
          if (mcnt == 8) begin
            mcnt = 0;
            mphase = !mphase;
          end
        end
      end
      mprev = vb;
    end
    #1;
    checks++;
    assert (dutv === m_out) else begin
      errors++;
      $error("FAIL stream obs=%h exp=%h", dutv, m_out);
    end
  endtask

  task automatic px(int hh, int vv, logic [11:0] c);
    h = 11'(hh); v = 11'(vv); hb = 0; vb = 0; rgb = c;
    cyc();
  endtask

  task automatic chk(string tag, logic [11:0] exp);
    hb = 1;
    cyc();
    checks++;
    assert (rgb_out === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, rgb_out, exp);
    end
  endtask

  task automatic frame(int x, int y, State s);
    xp = 12'(x); yp = 12'(y); st = s; hb = 1; vb = 0;
    cyc();
    vb = 1;
    cyc();
    vb = 0;
    cyc();
  endtask

  initial begin
    rst = 1; hs = 1; rgb = 12'hABC; h = 11'd5; v = 11'd5;
    repeat (3) begin
      cyc();
      checks++;
      assert (dutv === '0) else begin
        errors++;
        $error("FAIL reset obs=%h exp=0", dutv);
      end
    end
    rst = 0;
    px(5, 5, 12'hABC);
    hs = 0;
    chk("rst_pass", 12'hABC);

    frame(100, 0, IDLE);
    px(110, 505, BG); chk("body_in", BODY);
    px(99, 505, BG);  chk("left_out", BG);
    px(131, 505, BG); chk("right_col", EDGE_C);
    px(132, 505, BG); chk("right_out", BG);

    for (int i = 1; i <= 8; i++) begin
      frame(100, 0, RIGHT1);
      px(105, 540, BG);
      chk(i < 8 ? "leg_ph0" : "leg_ph1", i < 8 ? LEG : BG);
    end
    frame(100, 0, IDLE);
    px(105, 540, BG); chk("idle_ph0", LEG);

    frame(100, 0, LEFT1);
    px(106, 508, BG); chk("eyeL_a", EYE);
    px(109, 511, BG); chk("eyeL_b", EYE);
    px(110, 508, BG); chk("eyeL_off", BODY);
    frame(100, 0, IDLE);
    px(107, 509, BG); chk("eyeL_hold", EYE);
    frame(100, 0, RIGHT1);
    px(122, 508, BG); chk("eyeR_a", EYE);
    px(125, 511, BG); chk("eyeR_b", EYE);
    px(106, 508, BG); chk("eyeR_off", BODY);

    frame(100, 0, IDLE);
    xp = 12'd300;
    px(110, 300, BG);
    px(310, 505, BG); chk("mid_new", BG);
    px(110, 505, BG); chk("mid_old", BODY);
    frame(300, 0, IDLE);
    px(310, 505, BG); chk("mid_after", BODY);

    frame(1010, 0, IDLE);
    px(1010, 505, BG); chk("clip_l", EDGE_C);
    px(1023, 505, BG); chk("clip_r", BODY);
    px(5, 505, BG);    chk("no_wrap", BG);
    px(0, 505, BG);    chk("no_wrap0", BG);
    h = 11'd1015; v = 11'd505; hb = 1; rgb = BG;
    cyc();
    chk("hblnk", BG);
    frame(4090, 0, IDLE);
    px(0, 505, BG); chk("x4090_0", BG);
    px(5, 505, BG); chk("x4090_5", BG);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0)
        frame($urandom_range(0, 3) == 0 ? 4095 - int'($urandom_range(0, 40)) : int'($urandom_range(0, 1100)),
              int'($urandom_range(0, 300)), State'($urandom_range(0, 3)));
      else begin
        hs = 1'($urandom); vs = 1'($urandom);
        hb = $urandom_range(0, 9) == 0;
        vb = 0;
        h = 11'(mx + int'($urandom_range(0, 45)) - 5);
        v = 11'(500 + my + int'($urandom_range(0, 60)) - 5);
        rgb = 12'($urandom);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
